motor_duty_ramp: RTL and testbench

Slew-rate-limited duty-cycle controller sitting directly upstream of the 0–100 % PWM generator that drives the DC motor. It converts one-cycle button pulses from the button counters into a saturating setpoint. It moves the PWM duty toward that setpoint by one percent per ramp tick and sequences safe direction reversal by ramping through zero before flipping `dir`. Outputs `duty` to the PWM stage and `setpoint` to the BCD/FND display path.

---
 rtl/motor_ctrl_pkg.sv | 28 ++
 rtl/ramp_tick_gen.sv | 28 ++
 rtl/motor_duty_ramp.sv | 124 ++++++++++++
 tb/tb_motor_duty_ramp.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// Shared motor-control definitions: ramp state encoding, duty width, default ceiling,
// and the saturating setpoint helpers used by the duty ramp.
package motor_ctrl_pkg;

  localparam int DUTY_W       = 8;
  localparam int DUTY_MAX_DEF = 100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RAMP    = 2'd2,
    ST_REVERSE = 2'd3
  } ramp_state_e;

  // Sum is formed in 9 bits so a setpoint near 255 cannot wrap before the clamp.
  function automatic logic [DUTY_W-1:0] sp_inc(input logic [DUTY_W-1:0] sp,
                                               input int step, input int max);
    logic [DUTY_W:0] s;
    s = {1'b0, sp} + (DUTY_W+1)'(step);
    return (s > (DUTY_W+1)'(max)) ? DUTY_W'(max) : s[DUTY_W-1:0];
  endfunction

  function automatic logic [DUTY_W-1:0] sp_dec(input logic [DUTY_W-1:0] sp,
                                               input int step);
    return (sp >= DUTY_W'(step)) ? sp - DUTY_W'(step) : '0;
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running prescaler; tick_o pulses for one cycle every TICK_DIV clocks.
// clr_i restarts the count synchronously (used only by the emergency-stop build).
module ramp_tick_gen #(
  parameter int TICK_DIV = 2_000_000
) (
  input  logic clk,
  input  logic rstp,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(TICK_DIV-1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/motor_duty_ramp.sv
// Slew-limited PWM duty controller with saturating setpoint and ramp-through-zero reversal.
// Optional MOTOR_RAMP_ESTOP_EN: stop pulse forces duty/setpoint/prescaler to zero at once.
module motor_duty_ramp
  import motor_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 2_000_000,
  parameter int STEP     = 5,
  parameter int DUTY_MAX = DUTY_MAX_DEF
) (
  input  logic              clk,
  input  logic              rstp,
  input  logic              btn_up_pe,
  input  logic              btn_dn_pe,
  input  logic              btn_dir_pe,
  input  logic              btn_stop_pe,
  output logic [DUTY_W-1:0] duty,
  output logic [DUTY_W-1:0] setpoint,
  output logic              dir,
  output logic              busy
);

  ramp_state_e       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d, sp_q, sp_d;
  logic              dir_q, dir_d, busy_q, busy_d;
  logic              tick, tick_clr;
  logic [DUTY_W-1:0] sp_adj, duty_ramp;

  ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rstp   (rstp),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Resting state is implied by where duty lands relative to the setpoint.
  function automatic ramp_state_e settle(input logic [DUTY_W-1:0] d,
                                         input logic [DUTY_W-1:0] s);
    if (d != s)     return ST_RAMP;
    else if (d == 0) return ST_IDLE;
    else            return ST_HOLD;
  endfunction

  always_comb begin
    sp_adj = sp_q;
    if (btn_up_pe && !btn_dn_pe)      sp_adj = sp_inc(sp_q, STEP, DUTY_MAX);
    else if (btn_dn_pe && !btn_up_pe) sp_adj = sp_dec(sp_q, STEP);

    duty_ramp = duty_q;
    if (state_q == ST_RAMP && tick)
      duty_ramp = (duty_q > sp_q) ? duty_q - DUTY_W'(1) : duty_q + DUTY_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    sp_d     = sp_q;
    dir_d    = dir_q;
    tick_clr = 1'b0;

    if (state_q == ST_REVERSE) begin
      if (tick) duty_d = duty_q - DUTY_W'(1);
      if (btn_stop_pe) begin
        sp_d    = '0;
        state_d = settle(duty_d, '0);
      end else begin
        sp_d = sp_adj;
        if (duty_d == 0) begin
          dir_d   = ~dir_q;
          state_d = settle(duty_d, sp_adj);
        end
      end
    end else if (btn_stop_pe) begin
      duty_d  = duty_ramp;
      sp_d    = '0;
      state_d = settle(duty_ramp, '0);
    end else if (btn_dir_pe) begin
      // Duty is held on the accept cycle; reversal starts on the next tick.
      if (duty_q == 0) begin
        dir_d   = ~dir_q;
        state_d = settle(duty_q, sp_q);
      end else begin
        state_d = ST_REVERSE;
      end
    end else begin
      duty_d  = duty_ramp;
      sp_d    = sp_adj;
      state_d = settle(duty_ramp, sp_adj);
    end

`ifdef MOTOR_RAMP_ESTOP_EN
    if (btn_stop_pe) begin
      duty_d   = '0;
      sp_d     = '0;
      dir_d    = dir_q;
      state_d  = ST_IDLE;
      tick_clr = 1'b1;
    end
`endif

    busy_d = (state_d == ST_RAMP) || (state_d == ST_REVERSE);
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      sp_q    <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      sp_q    <= sp_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
    end
  end

  assign duty     = duty_q;
  assign setpoint = sp_q;
  assign dir      = dir_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_motor_duty_ramp.sv
// Self-checking bench for motor_duty_ramp: directed scenarios plus random button pulses
// against a value-level model (duty, setpoint, dir, reversing flag, tick phase).
module tb_motor_duty_ramp;
  localparam int TD = 4, ST = 5, MX = 100;

  logic       clk = 1'b0, rstp = 1'b1;
  logic       up = 0, dn = 0, dr = 0, sp_stop = 0;
  logic [7:0] duty, setpoint;
  logic       dir, busy;

  int total = 0, bad = 0;
  int m_duty, m_sp, m_dir, m_rev, m_cnt;

  motor_duty_ramp #(.TICK_DIV(TD), .STEP(ST), .DUTY_MAX(MX)) dut (
    .clk(clk), .rstp(rstp), .btn_up_pe(up), .btn_dn_pe(dn), .btn_dir_pe(dr),
    .btn_stop_pe(sp_stop), .duty(duty), .setpoint(setpoint), .dir(dir), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_busy();
    return (m_rev != 0 || m_duty != m_sp) ? 1 : 0;
  endfunction

  function automatic int adj(input int s, input bit u, input bit d);
    if (u && !d) return (s + ST > MX) ? MX : s + ST;
    if (d && !u) return (s - ST < 0) ? 0 : s - ST;
    return s;
  endfunction

  task automatic m_reset();
    m_duty = 0; m_sp = 0; m_dir = 0; m_rev = 0; m_cnt = 0;
  endtask

  // One clock of the reference: a tick moves duty one unit toward its goal.
  task automatic model_step(input bit u, input bit d, input bit r, input bit s);
    bit tk;
    tk = (m_cnt == TD-1);
    m_cnt = tk ? 0 : m_cnt + 1;
`ifdef MOTOR_RAMP_ESTOP_EN
    if (s) begin
      m_duty = 0; m_sp = 0; m_rev = 0; m_cnt = 0;
      return;
    end
`endif
    if (m_rev != 0) begin
      if (tk) m_duty--;
      if (s) begin
        m_sp = 0; m_rev = 0;
      end else begin
        m_sp = adj(m_sp, u, d);
        if (m_duty == 0) begin m_dir ^= 1; m_rev = 0; end
      end
    end else if (s) begin
      if (tk && m_duty != m_sp) m_duty += (m_sp > m_duty) ? 1 : -1;
      m_sp = 0;
    end else if (r) begin
      if (m_duty == 0) m_dir ^= 1;
      else             m_rev = 1;
    end else begin
      if (tk && m_duty != m_sp) m_duty += (m_sp > m_duty) ? 1 : -1;
      m_sp = adj(m_sp, u, d);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".duty"}, int'(duty), m_duty);
    chk({tag, ".sp"},   int'(setpoint), m_sp);
    chk({tag, ".dir"},  int'(dir), m_dir);
    chk({tag, ".busy"}, int'(busy), m_busy());
  endtask

  task automatic cyc(input bit u, input bit d, input bit r, input bit s, input string tag);
    up = u; dn = d; dr = r; sp_stop = s;
    @(posedge clk);
    model_step(u, d, r, s);
    #1;
    up = 0; dn = 0; dr = 0; sp_stop = 0;
    check_all(tag);
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    while (m_busy() != 0 && n < 1000) begin
      cyc(0, 0, 0, 0, tag);
      n++;
    end
    chk({tag, ".timeout"}, (n < 1000) ? 0 : 1, 0);
    cyc(0, 0, 0, 0, tag);
  endtask

  initial begin
    m_reset();
    #2;
    chk("rst.duty", int'(duty), 0);
    chk("rst.sp",   int'(setpoint), 0);
    chk("rst.dir",  int'(dir), 0);
    chk("rst.busy", int'(busy), 0);
    #20 rstp = 1'b0;
    @(posedge clk); model_step(0, 0, 0, 0); #1; check_all("rel");

    cyc(0, 1, 0, 0, "dn0");
    chk("dn0.sp_zero", int'(setpoint), 0);
    chk("dn0.idle", int'(busy), 0);

    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, "up3");
    chk("up3.sp15", int'(setpoint), 15);
    settle("ramp15");
    chk("ramp15.duty", int'(duty), 15);
    chk("ramp15.nobusy", int'(busy), 0);

    for (int i = 0; i < 25; i++) cyc(1, 0, 0, 0, "up25");
    chk("sat.sp100", int'(setpoint), 100);
    cyc(1, 0, 0, 0, "sat+1");
    chk("sat.keep100", int'(setpoint), 100);
    settle("ramp100");
    chk("ramp100.duty", int'(duty), 100);

    cyc(0, 0, 0, 1, "stop100");
    settle("stopdown");
    chk("stopdown.duty0", int'(duty), 0);

    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, "up20");
    settle("ramp20");
    cyc(0, 0, 1, 0, "rev");
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, "rev");
    cyc(0, 0, 1, 0, "rev2nd");
    settle("revdone");
    chk("rev.dir1", int'(dir), 1);
    chk("rev.duty20", int'(duty), 20);

    cyc(1, 1, 0, 0, "updn");
    chk("updn.sp20", int'(setpoint), 20);

    cyc(0, 0, 1, 1, "stopdir");
    chk("stopdir.dir", int'(dir), 1);
    settle("stopdir");

    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, "up50");
    settle("ramp50");
    chk("ramp50.duty", int'(duty), 50);
    cyc(0, 0, 0, 1, "stop50");
    settle("stop50");
    chk("stop50.duty0", int'(duty), 0);

    for (int i = 0; i < 400; i++) begin
      bit u, d, r, s;
      u = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 29) == 0);
      s = ($urandom_range(0, 59) == 0);
      cyc(u, d, r, s, "rnd");
    end
    settle("rnd");

    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, "pre_rst");
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, "pre_rst");
    rstp = 1'b1;
    m_reset();
    #1;
    chk("arst.duty", int'(duty), 0);
    chk("arst.sp",   int'(setpoint), 0);
    chk("arst.dir",  int'(dir), 0);
    chk("arst.busy", int'(busy), 0);
    #12 rstp = 1'b0;
    cyc(1, 0, 0, 0, "post_rst");
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, "post_rst");
    chk("post_rst.duty2", int'(duty), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
